// File: rtl/trace_request_queue.sv
// Trace request queue: keeps CPU time, derives the DRAM tick, admits requests
// once their timestamp is reached and releases them in order on DRAM ticks.
module trace_request_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CPU_PER_DRAM = 2,
  parameter int unsigned ADDR_W       = 33,
  parameter bit          SKIP_EN      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_time,
  input  logic [1:0]             in_core,
  input  logic [1:0]             in_op,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_core,
  output logic [1:0]             out_op,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [63:0]            out_time,
  output logic                   dram_tick,
  output logic [63:0]            cycle_count,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned PH_W    = (CPU_PER_DRAM > 1) ? $clog2(CPU_PER_DRAM) : 1;
  localparam int unsigned ENTRY_W = 64 + 2 + 2 + ADDR_W;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CPU_PER_DRAM - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [63:0]        cycle_q, cycle_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               tick_q, tick_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head_c;
  logic               push_c;
  logic               pop_c;

  // Full blocks admission even when a pop happens in the same cycle.
  assign in_ready = !full_q && (in_time <= cycle_q);
  assign push_c   = in_valid && in_ready;
  assign pop_c    = !empty_q && out_ready && tick_q;

  always_comb begin
    cycle_d  = cycle_q + 64'd1;
    phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    tick_d   = 1'b0;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    // Idle gaps in the trace are skipped only while nothing is waiting.
    if (SKIP_EN && empty_q && in_valid && (in_time > cycle_q + 64'd1)) begin
      cycle_d = in_time;
    end

    tick_d = (phase_d == PH_LAST);

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    full_d  = (occ_d == OCC_FULL);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      phase_q  <= '0;
      tick_q   <= 1'b0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head fields read as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= {cycle_q, in_core, in_op, in_addr};
    end
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign out_time    = head_c[ENTRY_W-1 -: 64];
  assign out_core    = head_c[ADDR_W+3 -: 2];
  assign out_op      = head_c[ADDR_W+1 -: 2];
  assign out_addr    = head_c[ADDR_W-1:0];
  assign out_valid   = !empty_q;
  assign dram_tick   = tick_q;
  assign cycle_count = cycle_q;
  assign occupancy   = occ_q;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule
